// File: rtl/shifter_byte_window.sv
// shifter_byte_window
// Byte-window stage behind the prefetch unit of the LZ4 compressor input path.
// Pulls 32-bit words over the pref_rd/pref_valid handshake into an 8-byte
// buffer. Presents the next four stream bytes to the match/literal logic,
// which consumes 0-4 bytes per cycle. Tracks the end of the current block.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           opens a new block (honoured only in IDLE or DONE)
//   pref_data       word from prefetch, stream byte 0 in [7:0]
//   pref_valid      pref_data holds a word
//   in_last         pref_data is the final word of the block
//   in_last_bytes   valid bytes in the final word (0 means 4)
//   pref_rd         registered fetch request; a word is accepted on pref_rd & pref_valid
//   shift_amt       bytes consumed downstream this cycle (0-4)
//   win_data        next stream bytes, byte k at [8k+7:8k], unused lanes read 0
//   win_count       valid bytes in win_data, min(occupancy, 4)
//   win_last        no bytes of the block exist beyond win_data
//   stream_done     block fully consumed
//   shift_err       sticky: shift_amt exceeded win_count
module shifter_byte_window (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pref_data,
    input  logic        pref_valid,
    input  logic        in_last,
    input  logic [1:0]  in_last_bytes,
    output logic        pref_rd,
    input  logic [2:0]  shift_amt,
    output logic [31:0] win_data,
    output logic [2:0]  win_count,
    output logic        win_last,
    output logic        stream_done,
    output logic        shift_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] buf_q, buf_d;
    logic [3:0]  occ_q, occ_d;
    logic        pref_rd_q, pref_rd_d;
    logic        shift_err_q, shift_err_d;
    logic        stream_done_q, stream_done_d;

    logic        accept;
    logic        over;
    logic [2:0]  s_amt;
    logic [3:0]  n_bytes;
    logic [3:0]  keep;
    logic [63:0] keep_mask;
    logic [31:0] word_mask;
    logic [31:0] word_m;

    // Window view depends only on registered buffer state.
    always_comb begin
        win_count = (occ_q > 4'd4) ? 3'd4 : occ_q[2:0];
        win_data  = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(win_count)) begin
                win_data[8*k +: 8] = buf_q[8*k +: 8];
            end
        end
    end

    always_comb begin
        accept = pref_rd_q & pref_valid;

        // Over-consumption is clipped to what the window actually holds.
        over  = (shift_amt > win_count);
        s_amt = over ? win_count : shift_amt;

        if (!accept) begin
            n_bytes = 4'd0;
        end else if (in_last && (in_last_bytes != 2'd0)) begin
            n_bytes = {2'b00, in_last_bytes};
        end else begin
            n_bytes = 4'd4;
        end

        // Bytes surviving the shift; new bytes land directly above them.
        keep = occ_q - {1'b0, s_amt};

        keep_mask = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < int'(keep)) begin
                keep_mask[8*j +: 8] = 8'hFF;
            end
        end

        word_mask = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < int'(n_bytes)) begin
                word_mask[8*j +: 8] = 8'hFF;
            end
        end
        word_m = pref_data & word_mask;

        // Stale bytes above occ are masked off, so the buffer never needs a reset.
        buf_d = ((buf_q >> {s_amt, 3'b000}) & keep_mask)
              | ({32'b0, word_m} << {keep, 3'b000});
        occ_d = keep + n_bytes;

        state_d     = state_q;
        shift_err_d = shift_err_q | over;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    buf_d       = '0;
                    occ_d       = '0;
                    shift_err_d = 1'b0;
                end
            end
            S_RUN: begin
                if (accept && in_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (occ_d == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Fetch only while a full word is guaranteed to fit next cycle.
        pref_rd_d     = (state_d == S_RUN) && (occ_d <= 4'd4);
        stream_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            occ_q         <= '0;
            pref_rd_q     <= 1'b0;
            shift_err_q   <= 1'b0;
            stream_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            occ_q         <= occ_d;
            pref_rd_q     <= pref_rd_d;
            shift_err_q   <= shift_err_d;
            stream_done_q <= stream_done_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign pref_rd     = pref_rd_q;
    assign shift_err   = shift_err_q;
    assign stream_done = stream_done_q;
    assign win_last    = (state_q == S_DRAIN) && (occ_q <= 4'd4);

endmodule

// File: doc/shifter_byte_window.md
# shifter_byte_window

Byte-window stage directly downstream of `shifter_prefetch` in the LZ4 compressor input path. It pulls 32-bit words through the prefetch `pref_rd`/`pref_data`/`pref_valid` handshake and buffers up to 8 bytes. It presents the next 4 stream bytes, aligned to an arbitrary byte offset, to the match/literal logic, which consumes 0–4 bytes per cycle. It also tracks the end of each LZ4 block and reports when the block's bytes are fully consumed.

## Interface
Parameters: none.
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle pulse that opens a new block; honoured only in IDLE or DONE
- `pref_data`  in  32  word from prefetch; byte 0 of the stream is in [7:0]
- `pref_valid`  in  1  `pref_data` holds a word
- `in_last`  in  1  qualifies `pref_data`: final word of the block
- `in_last_bytes`  in  2  valid bytes in the final word; 0 means 4
- `pref_rd`  out  1  registered; a word is accepted in any cycle with `pref_rd & pref_valid`
- `shift_amt`  in  3  bytes consumed by downstream this cycle, 0–4
- `win_data`  out  32  next bytes; stream byte k at [8k+7:8k]; lanes ≥ `win_count` read 0
- `win_count`  out  3  valid bytes in `win_data`, equal to min(occ,4)
- `win_last`  out  1  no bytes of the block exist beyond `win_data`
- `stream_done`  out  1  block fully consumed
- `shift_err`  out  1  sticky flag: `shift_amt` exceeded `win_count`

## Operation
- Storage: 64-bit buffer `buf` plus occupancy `occ` (0–8 bytes). Byte 0 of `buf` is the oldest byte.
- States:
  - IDLE: entered on reset.
  - RUN: fetching words.
  - DRAIN: last word accepted, no more fetches.
  - DONE: block fully consumed.
- Transitions:
  - IDLE/DONE → RUN on `start`. `buf`, `occ`, `shift_err` and `stream_done` clear; `pref_rd` is set to 1 on the same edge.
  - RUN → DRAIN on accepting a word with `in_last`=1.
  - DRAIN → DONE when occ_next is 0.
  - `start` in RUN or DRAIN is ignored.
- Effective shift: s = min(`shift_amt`, `win_count`). If `shift_amt` > `win_count`, `shift_err` is set and stays set until `start` or `rst`.
- Accepted bytes: n = 4 for a normal word. For a word with `in_last`=1, n = `in_last_bytes`, with 0 meaning 4. If no word is accepted, n = 0.
- Update each cycle:
  - `buf` = (`buf` >> 8s) | (masked word << 8(occ−s))
  - occ_next = occ − s + n
  - Byte lanes of the accepted word at or above n are masked to 0.
- `pref_rd` next value = (state_next == RUN) && (occ_next ≤ 4). This guarantees occ never exceeds 8.
- `pref_rd` is a pure register output. It must not depend combinationally on `pref_valid` or `pref_data`, because the prefetch stage muxes its data on `pref_rd`.
- `win_data` and `win_count` are combinational from `buf`/`occ` only. They do not depend on `shift_amt`.
- `win_last` = (state == DRAIN) && (occ ≤ 4).
- `stream_done` is registered and equals 1 exactly while in DONE.
- A zero-byte block is not supported; the controller never issues `start` for one.

## Timing
- Reset values:
  - `pref_rd`=0, `win_data`=0, `win_count`=0, `win_last`=0, `stream_done`=0, `shift_err`=0
  - `occ`=0, state=IDLE
- `rst` mid-block: abandons the block immediately. Everything returns to reset values on the next edge, and no word is accepted in that cycle.
- Latency:
  - `start` at cycle 0 → `pref_rd`=1 at cycle 1.
  - A word accepted at cycle 1 is visible in `win_data`/`win_count` at cycle 2.
- Throughput: sustains 4 bytes/cycle once occ ≥ 4 and `pref_valid` stays high.
- Simultaneous accept and shift in one cycle are both applied; the new bytes land at offset occ−s.
- `pref_valid`=0 while `pref_rd`=1: nothing is accepted, `pref_rd` stays high, and the window holds.
- DRAIN→DONE: `stream_done` rises on the edge after the shift that empties the buffer. `pref_rd` is already 0 from the edge that accepted the last word.

## Test plan
- **Aligned stream:** `start`, then words 0x44332211, 0x88776655 (last, `in_last_bytes`=0), `shift_amt`=4 whenever `win_count`=4 → `win_data` shows 0x44332211 then 0x88776655; `win_last`=1 on the second; `stream_done`=1 the cycle after the final shift.
- **Unaligned consume:** same two words, wait until occ=8, then `shift_amt`=3 → `win_data`=0x77665544 and `win_count`=4.
- **Short last word:** words 0x44332211 then 0xAABBCCDD (last, `in_last_bytes`=2), shifts 4 then 2 → second window is 0x0000CCDD with `win_count`=2 and `win_last`=1; `pref_rd` is 0 after the accept.
- **Bubbles and back-pressure:** `pref_valid` low for 3 cycles mid-stream with `shift_amt`=0 → `win_data`/`win_count` stable and no byte lost or duplicated; `pref_rd` falls when occ would exceed 4.
- **Illegal shift:** `win_count`=2, `shift_amt`=4 → 2 bytes consumed and `shift_err`=1; it stays 1 through DONE and clears on the next `start`.
- **Reset mid-block:** `rst` asserted while occ=6 in RUN → all outputs at reset values on the next edge; after a new `start` the first window is built from new words only.
